alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle controller that runs 6502-class ALU instructions on the shared 8-bit combinational ALU in the CPU core.
- Latches an opcode class, operands and incoming flags, then drives the ALU enable, operand and carry lines for one or two passes.
- Computes the N/Z/C/V flags and returns the result with a done pulse.
- Lets the CPU decoder issue one ALU op per handshake, without hand-built enable patterns per instruction.

Parameters:
- WIDTH, 8, datapath width; only 8 is supported, and flag bit positions assume 8.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  4  0 ADC, 1 SBC, 2 AND, 3 ORA, 4 EOR, 5 CMP, 6 ASL, 7 LSR, 8 ROL, 9 ROR, 10 INC, 11 DEC, 12 BIT, 13-15 illegal
- a_in  in  8  accumulator/operand A
- b_in  in  8  memory operand B
- c_in  in  1  current carry flag
- v_in  in  1  current overflow flag
- alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en, alu_inv_en  out  1 each  ALU operation controls
- alu_a, alu_b  out  8 each  ALU operand inputs
- alu_cin  out  1  ALU carry in
- alu_res  in  8  ALU result
- alu_cout  in  1  ALU carry out; for a shift-right this is the bit shifted out
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- result  out  8  registered result
- result_we  out  1  high with done when result must be written back
- n_out, z_out, c_out, v_out  out  1 each  registered flags, valid while done is high and held until the next start
- illegal  out  1  pulses with done for opcodes 13-15

Behaviour:
- States: IDLE, EXEC1, EXEC2, DONE. Async reset forces IDLE from any state, including mid-op.
- Reset values: all ALU controls 0; alu_a, alu_b, alu_cin 0; busy, done, result_we, illegal 0; result 0; flags 0.
- IDLE: on start=1 at a rising edge, latch op, a_in, b_in, c_in, v_in and go to EXEC1. Later input changes are ignored until the next IDLE.
- start outside IDLE is ignored; no queueing.
- EXEC1: exactly one ALU enable is high. Result and carry are registered at the end of the cycle. Next state is DONE, or EXEC2 for ROR only.
- EXEC2: exactly one ALU enable is high, then next state is DONE.
- DONE: done=1 for one cycle, then IDLE. Controls are 0 in IDLE and DONE.
- Latency: start sampled at edge k gives done high in the cycle after edge k+2. ROR takes one cycle more (edge k+3).
- EXEC1 drive per op (A and B are the latched operands):
  - ADC: SUM, a=A, b=B, cin=C.
  - SBC: SUM+INV, a=A, b=B, cin=C.
  - CMP: SUM+INV, a=A, b=B, cin=1.
  - AND, ORA, EOR: matching enable, a=A, b=B.
  - ASL: SUM, a=A, b=A, cin=0.
  - ROL: SUM, a=A, b=A, cin=C.
  - LSR: SR, a=A.
  - INC: SUM, a=A, b=0x00, cin=1.
  - DEC: SUM, a=A, b=0xFF, cin=0.
  - BIT: AND, a=A, b=B.
  - ROR: SR, a=A; store the ALU result in tmp and the shifted-out bit in save_c.
  - Illegal: no enables; result=A, flags unchanged.
- ROR EXEC2: OR, a=tmp, b={C,7'b0}; C flag is save_c.
- Flags:
  - N = result[7], Z = (result==0), except BIT.
  - BIT: Z = ((A&B)==0), N = B[7], V = B[6].
  - C = alu_cout for ADC, SBC, CMP, ASL, ROL, LSR. C = save_c for ROR. Otherwise C = c_in.
  - V for ADC/SBC is computed internally, not taken from the ALU: V = (A[7]==Beff[7]) && (res[7]!=A[7]), where Beff is B for ADC and ~B for SBC. Otherwise V = v_in.
- result_we = 1 with done except for CMP, BIT and illegal opcodes.
- Carry chain is 8-bit plus carry; no BCD mode.

Test Plan:
- ADC A=0x50 B=0x50 C=0, start at edge 0 -> done in cycle 3 (after edge 2); result=0xA0, N1 Z0 C0 V1, result_we=1.
- SBC A=0x50 B=0xF0 C=1 -> result=0x60, C0 V0 N0 Z0; alu_inv_en=1 and alu_sum_en=1 during EXEC1.
- CMP A=0x10 B=0x10 -> Z1 C1 N0, result_we=0; then BIT A=0x0F B=0xC0 -> Z1 N1 V1, result_we=0.
- ROR A=0x01 C=1 -> EXEC1 with SR, EXEC2 with OR and alu_b=0x80; done one cycle later than ADC; result=0x80, C1 N1 Z0.
- DEC A=0x00 -> 0xFF, N1, C equals c_in. Then start held high through busy: only one done pulse, and the second op is accepted only after IDLE.
- rst asserted during EXEC1 of ROR -> immediately IDLE, all outputs 0, no done. Opcode 14 -> done with illegal=1 and result_we=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives the shared 8-bit combinational ALU for one
// 6502-class ALU instruction per request. It runs one or two ALU passes,
// then registers the result, the N/Z/C/V flags and a one-cycle done pulse.
//
// Handshake: start is sampled only while busy=0 (state IDLE); the op,
// operands and flags are latched on that edge and later input changes are
// ignored. busy is high while the op runs. done pulses for exactly one cycle
// when result/flags become valid. result and flags hold until the next
// accepted start. start while busy is dropped; there is no queueing.
module alu_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             v_in,
  output logic             alu_sum_en,
  output logic             alu_and_en,
  output logic             alu_eor_en,
  output logic             alu_or_en,
  output logic             alu_sr_en,
  output logic             alu_inv_en,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic             n_out,
  output logic             z_out,
  output logic             c_out,
  output logic             v_out,
  output logic             illegal,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC1 = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORA = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_ASL = 4'd6;
  localparam logic [3:0] OP_LSR = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;
  localparam logic [3:0] OP_BIT = 4'd12;

  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             c_q, v_q, cout_q, save_c;

  // Final flag values, computed from the latched operands and ALU result
  logic             is_ill, nxt_n, nxt_z, nxt_c, nxt_v, nxt_we;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // Flag rules per opcode; consumed only in DONE
  always_comb begin
    is_ill = (op_q > OP_BIT);
    nxt_n  = res_q[MSB];
    nxt_z  = (res_q == '0);
    nxt_c  = c_q;
    nxt_v  = v_q;
    nxt_we = 1'b1;
    case (op_q)
      OP_ADC: begin
        nxt_c = cout_q;
        nxt_v = (a_q[MSB] == b_q[MSB]) && (res_q[MSB] != a_q[MSB]);
      end
      OP_SBC: begin
        nxt_c = cout_q;
        nxt_v = (a_q[MSB] == ~b_q[MSB]) && (res_q[MSB] != a_q[MSB]);
      end
      OP_CMP: begin
        nxt_c  = cout_q;
        nxt_we = 1'b0;
      end
      OP_ASL, OP_ROL, OP_LSR: nxt_c = cout_q;
      OP_ROR: nxt_c = save_c;
      OP_BIT: begin
        nxt_z  = ((a_q & b_q) == '0);
        nxt_n  = b_q[MSB];
        nxt_v  = b_q[MSB-1];
        nxt_we = 1'b0;
      end
      default: begin
        if (is_ill) nxt_we = 1'b0;
      end
    endcase
  end

  // Sequencer FSM: latch request, drive ALU passes, register result and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      save_c     <= 1'b0;
      alu_sum_en <= 1'b0;
      alu_and_en <= 1'b0;
      alu_eor_en <= 1'b0;
      alu_or_en  <= 1'b0;
      alu_sr_en  <= 1'b0;
      alu_inv_en <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      result_we  <= 1'b0;
      n_out      <= 1'b0;
      z_out      <= 1'b0;
      c_out      <= 1'b0;
      v_out      <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done      <= 1'b0;
          result_we <= 1'b0;
          illegal   <= 1'b0;
          if (start) begin
            op_q  <= op;
            a_q   <= a_in;
            b_q   <= b_in;
            c_q   <= c_in;
            v_q   <= v_in;
            state <= ST_EXEC1;
            // EXEC1 controls are set up on the accepting edge
            alu_sum_en <= 1'b0;
            alu_and_en <= 1'b0;
            alu_eor_en <= 1'b0;
            alu_or_en  <= 1'b0;
            alu_sr_en  <= 1'b0;
            alu_inv_en <= 1'b0;
            alu_a      <= a_in;
            alu_b      <= b_in;
            alu_cin    <= 1'b0;
            case (op)
              OP_ADC: begin alu_sum_en <= 1'b1; alu_cin <= c_in; end
              OP_SBC: begin alu_sum_en <= 1'b1; alu_inv_en <= 1'b1; alu_cin <= c_in; end
              OP_CMP: begin alu_sum_en <= 1'b1; alu_inv_en <= 1'b1; alu_cin <= 1'b1; end
              OP_AND, OP_BIT: alu_and_en <= 1'b1;
              OP_ORA: alu_or_en  <= 1'b1;
              OP_EOR: alu_eor_en <= 1'b1;
              OP_ASL: begin alu_sum_en <= 1'b1; alu_b <= a_in; end
              OP_ROL: begin alu_sum_en <= 1'b1; alu_b <= a_in; alu_cin <= c_in; end
              OP_LSR, OP_ROR: begin alu_sr_en <= 1'b1; alu_b <= '0; end
              OP_INC: begin alu_sum_en <= 1'b1; alu_b <= '0; alu_cin <= 1'b1; end
              OP_DEC: begin alu_sum_en <= 1'b1; alu_b <= '1; end
              default: begin alu_a <= '0; alu_b <= '0; end
            endcase
          end
        end
        ST_EXEC1: begin
          res_q      <= alu_res;
          cout_q     <= alu_cout;
          alu_sum_en <= 1'b0;
          alu_and_en <= 1'b0;
          alu_eor_en <= 1'b0;
          alu_sr_en  <= 1'b0;
          alu_inv_en <= 1'b0;
          alu_cin    <= 1'b0;
          if (op_q == OP_ROR) begin
            // Second pass ORs the old carry into bit 7; alu_a holds the
            // shifted value and save_c the bit shifted out
            save_c    <= alu_cout;
            alu_or_en <= 1'b1;
            alu_a     <= alu_res;
            alu_b     <= {c_q, {(WIDTH-1){1'b0}}};
            state     <= ST_EXEC2;
          end else begin
            alu_or_en <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            state     <= ST_DONE;
          end
        end
        ST_EXEC2: begin
          res_q     <= alu_res;
          alu_or_en <= 1'b0;
          alu_a     <= '0;
          alu_b     <= '0;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          done      <= 1'b1;
          illegal   <= is_ill;
          result_we <= nxt_we;
          result    <= is_ill ? a_q : res_q;
          if (!is_ill) begin
            n_out <= nxt_n;
            z_out <= nxt_z;
            c_out <= nxt_c;
            v_out <= nxt_v;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: bench for alu_op_sequencer with a behavioural ALU
// and an instruction-level reference model of 6502 ALU ops.
module tb_alu_op_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start;
  logic [3:0] op;
  logic [7:0] a_in, b_in;
  logic       c_in, v_in;
  logic       alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en, alu_inv_en;
  logic [7:0] alu_a, alu_b, alu_res;
  logic       alu_cin, alu_cout;
  logic       busy, done, result_we, n_out, z_out, c_out, v_out, illegal;
  logic [7:0] result;
  logic [1:0] dbg_state;

  alu_op_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .c_in(c_in), .v_in(v_in),
    .alu_sum_en(alu_sum_en), .alu_and_en(alu_and_en), .alu_eor_en(alu_eor_en),
    .alu_or_en(alu_or_en), .alu_sr_en(alu_sr_en), .alu_inv_en(alu_inv_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout),
    .busy(busy), .done(done), .result(result), .result_we(result_we),
    .n_out(n_out), .z_out(z_out), .c_out(c_out), .v_out(v_out),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  // Shared combinational ALU of the CPU core
  logic [8:0] alu_sum;
  logic [7:0] alu_beff;
  always_comb begin
    alu_beff = alu_inv_en ? ~alu_b : alu_b;
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_beff} + {8'd0, alu_cin};
    alu_res  = 8'h00;
    alu_cout = 1'b0;
    if (alu_sum_en) begin
      alu_res  = alu_sum[7:0];
      alu_cout = alu_sum[8];
    end else if (alu_and_en) alu_res = alu_a & alu_b;
    else if (alu_eor_en) alu_res = alu_a ^ alu_b;
    else if (alu_or_en)  alu_res = alu_a | alu_b;
    else if (alu_sr_en) begin
      alu_res  = {1'b0, alu_a[7:1]};
      alu_cout = alu_a[0];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic pn = 1'b0, pz = 1'b0, pc = 1'b0, pv = 1'b0;  // flags last reported

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] res;
    logic n, z, c, v, we, ill;
    int lat;
  } exp_t;

  function automatic int sx(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Instruction-level 6502 semantics with integer arithmetic
  function automatic exp_t model(input int opc, input int a, input int b, input int c, input int v);
    exp_t r;
    int t, s;
    r.c = c[0]; r.v = v[0]; r.we = 1'b1; r.ill = 1'b0; r.res = 8'h00;
    r.lat = (opc == 9) ? 3 : 2;
    case (opc)
      0: begin t = a + b + c; r.res = t[7:0]; r.c = (t > 255);
               s = sx(a) + sx(b) + c; r.v = (s > 127) || (s < -128); end
      1: begin t = a + (255 - b) + c; r.res = t[7:0]; r.c = (t > 255);
               s = sx(a) - sx(b) - (1 - c); r.v = (s > 127) || (s < -128); end
      2: r.res = 8'(a & b);
      3: r.res = 8'(a | b);
      4: r.res = 8'(a ^ b);
      5: begin t = a - b; r.res = t[7:0]; r.c = (a >= b); r.we = 1'b0; end
      6: begin t = a * 2; r.res = t[7:0]; r.c = (a >= 128); end
      7: begin r.res = 8'(a / 2); r.c = (a % 2) == 1; end
      8: begin t = a * 2 + c; r.res = t[7:0]; r.c = (a >= 128); end
      9: begin r.res = 8'(c * 128 + a / 2); r.c = (a % 2) == 1; end
      10: begin t = a + 1; r.res = t[7:0]; end
      11: begin t = a + 255; r.res = t[7:0]; end
      12: r.we = 1'b0;
      default: begin r.res = 8'(a); r.we = 1'b0; r.ill = 1'b1; end
    endcase
    r.n = (r.res >= 128);
    r.z = (r.res == 0);
    if (opc == 12) begin
      r.z = ((a & b) == 0); r.n = (b >= 128); r.v = ((b / 64) % 2) == 1; r.res = 8'(a & b);
    end
    if (r.ill) begin r.n = pn; r.z = pz; r.c = pc; r.v = pv; end
    return r;
  endfunction

  // Expected EXEC1 enables {sum, and, eor, or, sr, inv}
  function automatic logic [5:0] exp_ctl(input int opc);
    case (opc)
      0, 6, 8, 10, 11: return 6'b100000;
      1, 5:            return 6'b100001;
      2, 12:           return 6'b010000;
      3:               return 6'b000100;
      4:               return 6'b001000;
      7, 9:            return 6'b000010;
      default:         return 6'b000000;
    endcase
  endfunction

  function automatic logic [43:0] all_outs();
    return {alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en, alu_inv_en,
            alu_a, alu_b, alu_cin, busy, done, result, result_we,
            n_out, z_out, c_out, v_out, illegal, dbg_state, 5'd0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                           input logic c, input logic v);
    @(negedge clk);
    op = o; a_in = a; b_in = b; c_in = c; v_in = v; start = 1'b1;
  endtask

  task automatic scramble_inputs();
    op   = 4'($urandom_range(0, 15));
    a_in = 8'($urandom_range(0, 255));
    b_in = 8'($urandom_range(0, 255));
    c_in = 1'($urandom_range(0, 1));
    v_in = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic v);
    exp_t e;
    int cyc;
    logic seen;
    logic [7:0] er;
    e = model(int'(o), int'(a), int'(b), int'(c), int'(v));
    exp_q.push_back(e.res);
    drive_req(o, a, b, c, v);
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    check("exec1_en", {alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en, alu_inv_en},
          exp_ctl(int'(o)));
    check("busy_run", busy, 1'b1);
    if (o <= 4'd12) check("exec1_a", alu_a, a);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
      if (o == 4'd9 && cyc == 1) begin
        check("ror_state", dbg_state, 2'd2);
        check("ror_en2", {alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en, alu_inv_en},
              6'b000100);
        check("ror_b2", alu_b, {c, 7'd0});
        check("ror_a2", alu_a, {1'b0, a[7:1]});
      end
      if (done) seen = 1'b1;
    end
    er = exp_q.pop_front();
    check("done_lat", seen ? cyc : 99, e.lat);
    if (seen) begin
      if (o != 4'd5 && o != 4'd12) check("result", result, er);
      check("flags_nzcv", {n_out, z_out, c_out, v_out}, {e.n, e.z, e.c, e.v});
      check("we_ill", {result_we, illegal}, {e.we, e.ill});
      @(posedge clk); #1;
      check("done_pulse", done, 1'b0);
    end
    pn = e.n; pz = e.z; pc = e.c; pv = e.v;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dcnt;
    exp_t e;
    start = 1'b0; op = 4'd0; a_in = 8'd0; b_in = 8'd0; c_in = 1'b0; v_in = 1'b0;
    #1;
    check("reset_outs", all_outs(), 44'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(4'd0, 8'h50, 8'h50, 1'b0, 1'b0);   // ADC -> A0, N1 Z0 C0 V1
    run_op(4'd1, 8'h50, 8'hF0, 1'b1, 1'b1);   // SBC -> 60, V0 C0
    run_op(4'd5, 8'h10, 8'h10, 1'b0, 1'b0);   // CMP equal
    run_op(4'd12, 8'h0F, 8'hC0, 1'b0, 1'b0);  // BIT
    run_op(4'd9, 8'h01, 8'h00, 1'b1, 1'b0);   // ROR -> 80, C1
    run_op(4'd11, 8'h00, 8'h00, 1'b1, 1'b0);  // DEC wrap, C kept
    run_op(4'd14, 8'h5A, 8'h33, 1'b0, 1'b1);  // illegal

    // start held high: one done per op, second op only after IDLE
    e = model(11, 0, 0, 1, 0);
    drive_req(4'd11, 8'h00, 8'h00, 1'b1, 1'b0);
    @(posedge clk);
    dcnt = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
      if (i == 2) begin
        check("held_idle", busy, 1'b0);
        check("held_res", {result, n_out, c_out}, {e.res, e.n, e.c});
      end
      if (i == 3) check("held_rebusy", busy, 1'b1);
    end
    check("held_one_done", dcnt, 1);
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("held_second", dcnt, 1);
    pn = e.n; pz = e.z; pc = e.c; pv = e.v;

    // Reset during EXEC1 of ROR
    drive_req(4'd9, 8'h03, 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    check("rst_pre_state", dbg_state, 2'd1);
    #1 rst = 1'b1;
    #1 check("rst_mid_outs", all_outs(), 44'd0);
    @(negedge clk);
    rst = 1'b0;
    pn = 1'b0; pz = 1'b0; pc = 1'b0; pv = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("rst_no_done", dcnt, 0);

    // Randomized ops over all opcodes
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
